alu_program_seq: RTL and testbench

Programmable sequencer for the 8-bit accumulator ALU (add, multiply, shift-left, load). It holds a short program of ALU instructions written through a load port. On `start` it executes the program one instruction per clock against an internal 8-bit accumulator, then pulses `done`. It sits between the lab's switch/bus interface and the accumulator datapath, replacing manual single-stepping of `Function`/`Data`.

---
 rtl/alu_program_seq.sv | 119 +++++++++++
 tb/tb_alu_program_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_program_seq.sv
// Programmable sequencer for the 8-bit accumulator ALU.
// Holds a small instruction program and executes it one entry per clock on start.
module alu_program_seq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          Clock,
  input  logic          Reset_b,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_instr,
  input  logic          start,
  input  logic          pause,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [7:0]    acc_out,
  output logic          ovf
);

  localparam int unsigned DW   = 8;
  localparam int unsigned WIDE = 24;  // holds 255 << 15 without loss

  typedef struct packed {
    logic       last;
    logic [2:0] fn;
    logic [3:0] data;
  } instr_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   pc_d;
  logic [DW-1:0]   acc_d;
  logic            ovf_d, busy_d, done_d;
  logic [DW-1:0]   prog_mem [DEPTH];
  instr_t          cur;
  logic [WIDE-1:0] res;
  logic            trunc;

  // Program store: reset fills every entry with last+nop; writes blocked in RUN.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      for (int unsigned i = 0; i < DEPTH; i++) prog_mem[i] <= 8'hC0;
    end else if (prog_we && state != S_RUN) begin
      prog_mem[prog_addr] <= prog_instr;
    end
  end

  assign cur = instr_t'(prog_mem[pc]);

  // Full-width ALU result; the low byte feeds the accumulator.
  always_comb begin
    res = WIDE'(acc_out);
    unique case (cur.fn)
      3'd0:    res = WIDE'(acc_out) + WIDE'(cur.data);
      3'd1:    res = WIDE'(acc_out) * WIDE'(cur.data);
      3'd2:    res = WIDE'(acc_out) << cur.data;
      3'd3:    res = WIDE'(cur.data);
      default: res = WIDE'(acc_out);
    endcase
  end

  assign trunc = (cur.fn < 3'd3) && (|res[WIDE-1:DW]);

  always_comb begin
    state_d = state;
    pc_d    = pc;
    acc_d   = acc_out;
    ovf_d   = ovf;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        if (!pause) begin
          acc_d = res[DW-1:0];
          ovf_d = ovf | trunc;
          if (cur.last || pc == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pc_d = pc + AW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state   <= S_IDLE;
      pc      <= '0;
      acc_out <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      acc_out <= acc_d;
      ovf     <= ovf_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_program_seq.sv
// Self-checking bench for alu_program_seq: directed program table, random programs
// against a behavioural model, and hand-written pause/write/reset sequences.
module tb_alu_program_seq;

  logic       Clock = 1'b0;
  logic       Reset_b;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [7:0] prog_instr;
  logic       start;
  logic       pause;
  logic       busy, done, ovf;
  logic [2:0] pc;
  logic [7:0] acc_out;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mem_model [8];
  int         model_acc;

  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][7:0] ins;
    logic [7:0]      exp_acc;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs [6];

  alu_program_seq #(.DEPTH(8), .AW(3)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_instr(prog_instr), .start(start), .pause(pause), .busy(busy),
    .done(done), .pc(pc), .acc_out(acc_out), .ovf(ovf)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem_model[i] = 8'hC0;
    model_acc = 0;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] ins);
    @(negedge Clock);
    prog_we = 1'b1; prog_addr = a; prog_instr = ins;
    @(negedge Clock);
    prog_we = 1'b0;
    mem_model[a] = ins;
  endtask

  // Reference: walk the modelled program from entry 0 with plain integer arithmetic.
  task automatic predict(output int n, output int accs [8], output int ovfs [8]);
    int a, r, d, f;
    bit o;
    a = model_acc; o = 0; n = 0;
    for (int i = 0; i < 8; i++) begin
      f = int'(mem_model[i][6:4]);
      d = int'(mem_model[i][3:0]);
      case (f)
        0: r = a + d;
        1: r = a * d;
        2: r = a * (1 << d);
        3: r = d;
        default: r = a;
      endcase
      if (f < 3 && r > 255) o = 1;
      a = r % 256;
      accs[i] = a; ovfs[i] = int'(o);
      n = i + 1;
      if (mem_model[i][7]) break;
    end
  endtask

  // One run from start to idle, checked every cycle. Optionally writes together with
  // start (IDLE) or pokes prog_we/start during RUN (both should be ignored).
  task automatic do_run(input bit wr_with_start, input bit poke_in_run,
                        input logic [2:0] wa, input logic [7:0] wi);
    int n;
    int accs [8];
    int ovfs [8];
    @(negedge Clock);
    start = 1'b1;
    if (wr_with_start) begin
      prog_we = 1'b1; prog_addr = wa; prog_instr = wi;
      mem_model[wa] = wi;
    end
    predict(n, accs, ovfs);
    @(negedge Clock);
    start = 1'b0; prog_we = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("pc_after_start", int'(pc), 0);
    chk("ovf_cleared", int'(ovf), 0);
    chk("acc_kept", int'(acc_out), model_acc);
    if (poke_in_run) begin
      start = 1'b1; prog_we = 1'b1; prog_addr = wa; prog_instr = wi;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge Clock);
      start = 1'b0; prog_we = 1'b0;
      chk("acc_step", int'(acc_out), accs[k-1]);
      chk("ovf_step", int'(ovf), ovfs[k-1]);
      if (k < n) begin
        chk("busy_run", int'(busy), 1);
        chk("pc_run", int'(pc), k);
        chk("done_early", int'(done), 0);
      end else begin
        chk("done_pulse", int'(done), 1);
        chk("busy_fall", int'(busy), 0);
        chk("pc_last", int'(pc), n - 1);
      end
    end
    @(negedge Clock);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    model_acc = accs[n-1];
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) write(3'(i), v.ins[i]);
  endtask

  initial begin
    Reset_b = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_instr = '0;
    start = 1'b0; pause = 1'b0;
    model_reset();

    vecs[0] = '{n: 4, ins: {8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'h14, 8'h03, 8'h35}, exp_acc: 8'h40, exp_ovf: 1'b0};
    vecs[1] = '{n: 4, ins: {8'h00, 8'h00, 8'h00, 8'h00, 8'h9F, 8'h0F, 8'h1F, 8'h3F}, exp_acc: 8'h10, exp_ovf: 1'b1};
    vecs[2] = '{n: 2, ins: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA9, 8'h31}, exp_acc: 8'h00, exp_ovf: 1'b1};
    vecs[3] = '{n: 2, ins: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA7, 8'h31}, exp_acc: 8'h80, exp_ovf: 1'b0};
    vecs[4] = '{n: 8, ins: {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h30}, exp_acc: 8'h07, exp_ovf: 1'b0};
    vecs[5] = '{n: 3, ins: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h45, 8'h39}, exp_acc: 8'h09, exp_ovf: 1'b0};

    repeat (3) @(negedge Clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_ovf", int'(ovf), 0);
    Reset_b = 1'b1;

    // Default program after reset: one last+nop entry.
    do_run(0, 0, 3'd0, 8'h00);
    chk("default_acc", int'(acc_out), 0);

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      do_run(0, 0, 3'd0, 8'h00);
      chk("vec_acc", int'(acc_out), int'(vecs[v].exp_acc));
      chk("vec_ovf", int'(ovf), int'(vecs[v].exp_ovf));
    end

    // Pause for 3 cycles after the second instruction.
    load_vec(vecs[0]);
    @(negedge Clock); start = 1'b1;
    @(negedge Clock); start = 1'b0;
    @(negedge Clock); chk("p_acc1", int'(acc_out), 8'h05);
    @(negedge Clock); chk("p_acc2", int'(acc_out), 8'h08);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("p_hold_acc", int'(acc_out), 8'h08);
      chk("p_hold_pc", int'(pc), 2);
      chk("p_hold_busy", int'(busy), 1);
      chk("p_hold_done", int'(done), 0);
    end
    pause = 1'b0;
    @(negedge Clock); chk("p_acc3", int'(acc_out), 8'h20); chk("p_pc3", int'(pc), 3);
    @(negedge Clock); chk("p_done", int'(done), 1); chk("p_acc4", int'(acc_out), 8'h40);
    @(negedge Clock); chk("p_done_off", int'(done), 0);
    model_acc = 8'h40;

    // Write and start during RUN are dropped; rerun shows entry 3 intact.
    do_run(0, 1, 3'd3, 8'h30);
    do_run(0, 0, 3'd0, 8'h00);
    chk("run_write_dropped", int'(acc_out), 8'h40);

    // Write entry 0 in the same cycle as start: new entry executes.
    do_run(1, 0, 3'd0, 8'hB6);
    chk("wr_start_acc", int'(acc_out), 8'h06);

    // Randomised programs.
    for (int r = 0; r < 25; r++) begin
      int nw;
      logic [7:0] ins;
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        ins = 8'($urandom);
        if ($urandom_range(0, 3) != 0) ins[7] = 1'b0;
        write(3'($urandom_range(0, 7)), ins);
      end
      do_run(0, 0, 3'd0, 8'h00);
    end

    // Asynchronous reset off the clock edge, mid-run.
    load_vec(vecs[1]);
    @(negedge Clock); start = 1'b1;
    @(negedge Clock); start = 1'b0;
    @(negedge Clock);
    @(negedge Clock); chk("pre_rst_acc", int'(acc_out), 8'hE1);
    #2 Reset_b = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_acc", int'(acc_out), 0);
    chk("arst_pc", int'(pc), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_done", int'(done), 0);
    @(negedge Clock); Reset_b = 1'b1;
    model_reset();
    do_run(0, 0, 3'd0, 8'h00);
    chk("post_rst_acc", int'(acc_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
